// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: sequences 1/2/3-byte opcode fetches, drives PC load/increment and hands ir/operand to execute.
// Optional interrupt entry at instruction boundaries is compiled in with `define FETCH_IRQ_EN.
module fetch_sequencer #(
  parameter int                 ADDR_W    = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC = ADDR_W'(16'h0000),
  parameter logic [ADDR_W-1:0]  IRQ_VEC   = ADDR_W'(16'h00F0)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_ld,
  output logic [ADDR_W-1:0] pc_ld_val,
  output logic              pc_inc,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        ir,
  output logic [15:0]       operand,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              jump_req,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
`ifdef FETCH_IRQ_EN
  input  logic              irq,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] ret_pc,
`endif
  output logic              halted,
  output logic [15:0]       retired_cnt
);

  // state  | meaning
  // BOOT   | after reset; one cycle later pulses pc_ld with RESET_VEC
  // IDLE   | waiting for run
  // FETCH  | reading the opcode byte
  // OPR_LO | reading operand low byte
  // OPR_HI | reading operand high byte (3-byte opcodes only)
  // ISSUE  | ir/operand valid, waiting for exec_done
  // HALT   | stopped until reset
  typedef enum logic [2:0] {
    S_BOOT,
    S_IDLE,
    S_FETCH,
    S_OPR_LO,
    S_OPR_HI,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t state, state_nxt;
  logic   boot_armed;
  logic   is3;
  logic   ack;
  logic   in_fetch;
  logic   take_irq;

  assign ack      = mem_req & mem_ack;
  assign in_fetch = (state == S_FETCH) || (state == S_OPR_LO) || (state == S_OPR_HI);

`ifdef FETCH_IRQ_EN
  assign take_irq = (state == S_ISSUE) & exec_done & ~halt & irq;
  assign irq_ack  = take_irq;
`else
  logic unused_pc;
  assign take_irq  = 1'b0;
  assign unused_pc = ^pc_in;
`endif

  assign instr_valid = (state == S_ISSUE);
  assign halted      = (state == S_HALT);

  always_comb begin
    state_nxt = state;
    pc_ld     = 1'b0;
    pc_ld_val = RESET_VEC;
    pc_inc    = 1'b0;
    case (state)
      S_BOOT: begin
        if (boot_armed) begin
          pc_ld     = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (ack) begin
          pc_inc    = 1'b1;
          state_nxt = (mem_rdata[7:6] == 2'b00) ? S_ISSUE : S_OPR_LO;
        end
      end
      S_OPR_LO: begin
        if (ack) begin
          pc_inc    = 1'b1;
          state_nxt = is3 ? S_OPR_HI : S_ISSUE;
        end
      end
      S_OPR_HI: begin
        if (ack) begin
          pc_inc    = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (exec_done) begin
          if (halt) begin
            state_nxt = S_HALT;
          end else if (take_irq) begin
            // interrupt entry wins over any jump redirect and ignores run
            pc_ld     = 1'b1;
            pc_ld_val = IRQ_VEC;
            state_nxt = S_FETCH;
          end else begin
            if (jump_req) begin
              pc_ld     = 1'b1;
              pc_ld_val = jump_addr;
            end
            state_nxt = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BOOT;
      boot_armed <= 1'b0;
      mem_req    <= 1'b0;
    end else begin
      state      <= state_nxt;
      boot_armed <= (state == S_BOOT);
      // request is registered off the current state, so each byte read starts
      // one cycle after entering its state and always leaves a gap after an ack
      mem_req    <= in_fetch & ~ack;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir      <= 8'h00;
      operand <= 16'h0000;
      is3     <= 1'b0;
    end else if (ack) begin
      if (state == S_FETCH) begin
        ir      <= mem_rdata;
        operand <= 16'h0000;
        is3     <= mem_rdata[7];
      end else if (state == S_OPR_LO) begin
        operand[7:0] <= mem_rdata;
      end else if (state == S_OPR_HI) begin
        operand[15:8] <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= 16'h0000;
    end else if ((state == S_ISSUE) && exec_done) begin
      retired_cnt <= retired_cnt + 16'd1;
    end
  end

`ifdef FETCH_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_pc <= '0;
    end else if (take_irq) begin
      ret_pc <= jump_req ? jump_addr : pc_in;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected instructions and PC loads, a monitor pops and compares.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] pc_in;
  logic        pc_ld;
  logic [15:0] pc_ld_val;
  logic        pc_inc;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  ir;
  logic [15:0] operand;
  logic        instr_valid;
  logic        exec_done = 1'b0;
  logic        jump_req = 1'b0;
  logic [15:0] jump_addr = 16'h0000;
  logic        halt = 1'b0;
  logic        halted;
  logic [15:0] retired_cnt;
`ifdef FETCH_IRQ_EN
  logic        irq = 1'b0;
  logic        irq_ack;
  logic [15:0] ret_pc;
`endif

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_W   (16),
    .RESET_VEC(16'h0000),
    .IRQ_VEC  (16'h00F0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .pc_in      (pc_in),
    .pc_ld      (pc_ld),
    .pc_ld_val  (pc_ld_val),
    .pc_inc     (pc_inc),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .ir         (ir),
    .operand    (operand),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .jump_req   (jump_req),
    .jump_addr  (jump_addr),
    .halt       (halt),
`ifdef FETCH_IRQ_EN
    .irq        (irq),
    .irq_ack    (irq_ack),
    .ret_pc     (ret_pc),
`endif
    .halted     (halted),
    .retired_cnt(retired_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [23:0] q_instr[$];
  logic [15:0] q_ld[$];
  logic [7:0]  mem_q[$];
  int          wait_cyc = 0;
  int          wcnt = 0;
  int          n_inc = 0;
  int          n_ld = 0;
  int          n_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // program counter model driven by the DUT's load/increment pulses
  logic [15:0] pc = 16'hABCD;
  always @(posedge clk) begin
    if (pc_ld) pc <= pc_ld_val;
    else if (pc_inc) pc <= pc + 16'd1;
  end
  assign pc_in = pc;

  // instruction memory: answers a held request after wait_cyc cycles
  always @(negedge clk) begin
    if (rst_n && mem_req) begin
      if (wcnt >= wait_cyc && mem_q.size() > 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_q.pop_front();
        wcnt      = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
  end

  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (pc_ld) begin
        n_ld++;
        check("pc_ld_and_pc_inc", 32'(pc_inc), 32'd0);
        if (q_ld.size() == 0) fail($sformatf("unexpected_pc_ld value=%0h", pc_ld_val));
        else check("pc_ld_val", 32'(pc_ld_val), 32'(q_ld.pop_front()));
      end
      if (pc_inc) n_inc++;
      if (mem_req) n_req++;
      if (prev_req && !mem_req) check("mem_req_held_until_ack", 32'(prev_ack), 32'd1);
      if (instr_valid && !prev_valid) begin
        if (q_instr.size() == 0) fail($sformatf("unexpected_instr ir=%0h operand=%0h", ir, operand));
        else check("ir_operand", 32'({ir, operand}), 32'(q_instr.pop_front()));
      end
    end
    prev_req   = rst_n & mem_req;
    prev_ack   = mem_ack;
    prev_valid = rst_n & instr_valid;
  end

  task automatic wait_valid(input string name, input int budget, output int n);
    n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!instr_valid) fail({name, "_timeout"});
  endtask

  task automatic exec(input logic j, input logic [15:0] a, input logic h);
    exec_done = 1'b1;
    jump_req  = j;
    jump_addr = a;
    halt      = h;
    @(negedge clk);
    exec_done = 1'b0;
    jump_req  = 1'b0;
    jump_addr = 16'h0000;
    halt      = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int inc0;
    int req0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_pc_ld", 32'(pc_ld), 32'd0);
    check("rst_pc_inc", 32'(pc_inc), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_ir_operand", 32'({ir, operand}), 32'd0);
    check("rst_retired", 32'(retired_cnt), 32'd0);
    check("rst_pc_ld_val", 32'(pc_ld_val), 32'h0000);

    // boot load, then idle with run low
    q_ld.push_back(16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("boot_ld_count", 32'(n_ld), 32'd1);
    check("boot_pc", 32'(pc), 32'h0000);
    check("idle_no_req", 32'(n_req), 32'd0);

    // 1-byte opcode, zero-wait memory
    wait_cyc = 0;
    mem_q.push_back(8'h05);
    q_instr.push_back({8'h05, 16'h0000});
    inc0 = n_inc;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_valid("one_byte", 20, n);
    check("one_byte_latency", 32'(n), 32'd2);
    check("one_byte_inc", 32'(n_inc - inc0), 32'd1);
    check("one_byte_pc", 32'(pc), 32'h0001);
    exec(1'b0, 16'h0000, 1'b0);
    check("one_byte_retired", 32'(retired_cnt), 32'd1);
    check("valid_drops", 32'(instr_valid), 32'd0);

    // 3-byte opcode, two wait cycles per byte, then jump
    wait_cyc = 2;
    mem_q.push_back(8'h80);
    mem_q.push_back(8'h34);
    mem_q.push_back(8'h12);
    q_instr.push_back({8'h80, 16'h1234});
    inc0 = n_inc;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_valid("three_byte", 60, n);
    check("three_byte_inc", 32'(n_inc - inc0), 32'd3);
    check("three_byte_pc", 32'(pc), 32'h0004);
    q_ld.push_back(16'h0100);
    exec(1'b1, 16'h0100, 1'b0);
    check("jump_pc", 32'(pc), 32'h0100);
    check("jump_retired", 32'(retired_cnt), 32'd2);
    @(negedge clk);
    check("jump_idle_no_req", 32'(mem_req), 32'd0);

    // 2-byte opcode, then jump together with halt: halt wins, no load
    wait_cyc = 0;
    mem_q.push_back(8'h41);
    mem_q.push_back(8'h7E);
    q_instr.push_back({8'h41, 16'h007E});
    run = 1'b1;
    @(negedge clk);
    wait_valid("two_byte", 30, n);
    check("two_byte_pc", 32'(pc), 32'h0102);
    exec(1'b1, 16'h0100, 1'b1);
    check("halted", 32'(halted), 32'd1);
    req0 = n_req;
    repeat (8) @(negedge clk);
    check("halt_no_req", 32'(n_req - req0), 32'd0);
    check("halt_stays", 32'(halted), 32'd1);
    check("halt_retired", 32'(retired_cnt), 32'd3);
    check("halt_pc", 32'(pc), 32'h0102);

    // reset leaves HALT
    run = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    q_ld.push_back(16'h0000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("halt_exit_halted", 32'(halted), 32'd0);
    check("halt_exit_pc", 32'(pc), 32'h0000);

    // reset while waiting on the operand high byte
    wait_cyc = 3;
    mem_q.push_back(8'hC0);
    mem_q.push_back(8'h11);
    mem_q.push_back(8'h22);
    inc0 = n_inc;
    run = 1'b1;
    n = 0;
    while (!((n_inc - inc0) == 2 && mem_req) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) fail("opr_hi_reach_timeout");
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    run = 1'b0;
    mem_q.delete();
    @(negedge clk);
    q_ld.push_back(16'h0000);
    rst_n = 1'b1;
    req0 = n_req;
    repeat (4) @(negedge clk);
    check("rst_reboot_pc", 32'(pc), 32'h0000);
    check("rst_reboot_retired", 32'(retired_cnt), 32'd0);
    check("rst_reboot_no_req", 32'(n_req - req0), 32'd0);

    // retired counter wrap from a preset value
    force dut.retired_cnt = 16'hFFFE;
    #1;
    release dut.retired_cnt;
    #1;
    check("preset_retired", 32'(retired_cnt), 32'hFFFE);
    wait_cyc = 0;
    mem_q.push_back(8'h08);
    mem_q.push_back(8'h3F);
    q_instr.push_back({8'h08, 16'h0000});
    q_instr.push_back({8'h3F, 16'h0000});
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    wait_valid("wrap_a", 20, n);
    exec(1'b0, 16'h0000, 1'b0);
    check("wrap_ffff", 32'(retired_cnt), 32'hFFFF);
    wait_valid("wrap_b", 20, n);
    run = 1'b0;
    exec(1'b0, 16'h0000, 1'b0);
    check("wrap_zero", 32'(retired_cnt), 32'h0000);
    check("wrap_pc", 32'(pc), 32'h0002);

`ifdef FETCH_IRQ_EN
    // interrupt at an instruction boundary overrides a pending jump
    mem_q.push_back(8'h00);
    q_instr.push_back({8'h00, 16'h0000});
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    wait_valid("irq_instr", 20, n);
    q_ld.push_back(16'h00F0);
    mem_q.push_back(8'h01);
    q_instr.push_back({8'h01, 16'h0000});
    irq = 1'b1;
    exec_done = 1'b1;
    jump_req = 1'b1;
    jump_addr = 16'h0200;
    #1;
    check("irq_ack_pulse", 32'(irq_ack), 32'd1);
    @(negedge clk);
    irq = 1'b0;
    exec_done = 1'b0;
    jump_req = 1'b0;
    jump_addr = 16'h0000;
    check("irq_ack_drop", 32'(irq_ack), 32'd0);
    check("irq_ret_pc", 32'(ret_pc), 32'h0200);
    check("irq_pc", 32'(pc), 32'h00F0);
    wait_valid("irq_fetch_without_run", 20, n);
    check("irq_handler_pc", 32'(pc), 32'h00F1);
    exec(1'b0, 16'h0000, 1'b0);
`endif

    repeat (3) @(negedge clk);
    check("instr_queue_drained", 32'(q_instr.size()), 32'd0);
    check("ld_queue_drained", 32'(q_ld.size()), 32'd0);
    check("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller that drives the program counter's load/increment controls and an 8-bit instruction memory read handshake. It fetches a 1-, 2- or 3-byte instruction, presents the opcode and operand to the execute stage, then redirects or advances the PC. It sits between the program counter, the instruction memory and the execute/control unit.

Parameters:
ADDR_W, 16, PC and jump address width
RESET_VEC, 16'h0000, PC value loaded after reset
IRQ_VEC, 16'h00F0, interrupt vector (used only with the optional feature)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  permits starting a new instruction fetch
pc_in  in  ADDR_W  current program counter value
pc_ld  out  1  one-cycle pulse: PC loads pc_ld_val
pc_ld_val  out  ADDR_W  value to load into PC
pc_inc  out  1  one-cycle pulse: PC increments
mem_req  out  1  instruction memory read request (address = pc_in)
mem_ack  in  1  read data valid this cycle
mem_rdata  in  8  instruction byte
ir  out  8  latched opcode
operand  out  16  latched operand, little-endian
instr_valid  out  1  ir/operand valid, held until exec_done
exec_done  in  1  execute stage finished the current instruction
jump_req  in  1  sampled with exec_done: redirect PC
jump_addr  in  ADDR_W  redirect target
halt  in  1  sampled with exec_done: stop fetching
halted  out  1  in HALT state
retired_cnt  out  16  instructions completed, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async, immediate): state BOOT; pc_ld, pc_inc, mem_req, instr_valid and halted = 0; ir, operand and retired_cnt = 0; pc_ld_val = RESET_VEC.
- BOOT: first clock after reset release -> pc_ld=1 with pc_ld_val=RESET_VEC for exactly one cycle -> IDLE.
- IDLE: run=1 -> FETCH on the next edge. Otherwise hold.
- FETCH: mem_req=1 until mem_ack. In the ack cycle, ir<=mem_rdata, operand<=0 and pc_inc=1 for that cycle. Length comes from the opcode: mem_rdata[7:6]=00 -> 1 byte (-> ISSUE); 01 -> 2 bytes; 1x -> 3 bytes (-> OPR_LO).
- OPR_LO: mem_req=1. On ack: operand[7:0]<=mem_rdata, pc_inc=1. Next state is ISSUE for 2-byte instructions, OPR_HI for 3-byte.
- OPR_HI: mem_req=1. On ack: operand[15:8]<=mem_rdata, pc_inc=1 -> ISSUE.
- mem_req deasserts in the cycle after each ack. Minimum gap between byte requests is 1 cycle. No request is issued while in ISSUE.
- ISSUE: instr_valid=1. ir and operand are stable until exec_done. When exec_done=1, retired_cnt increments and the next state is chosen in this priority order:
  1. halt=1 -> HALT. Any jump_req is discarded.
  2. jump_req=1 -> pc_ld=1 with pc_ld_val=jump_addr for that cycle, then FETCH if run=1, else IDLE.
  3. Otherwise -> FETCH if run=1, else IDLE.
- instr_valid drops the cycle after exec_done.
- run deasserted mid-instruction: the current instruction completes through ISSUE, then the block goes to IDLE.
- HALT: halted=1 and all requests are 0. Only reset exits this state.
- pc_ld and pc_inc are never asserted in the same cycle.
- Latency: 1-byte instruction with zero-wait memory takes 2 cycles from FETCH entry to instr_valid.

Optional Feature:
FETCH_IRQ_EN
- Enabled: adds ports irq (in, 1), irq_ack (out, 1) and ret_pc (out, ADDR_W).
- At exec_done with halt=0 and irq=1:
  - ret_pc <= jump_addr if jump_req, else pc_in.
  - pc_ld=1 with pc_ld_val=IRQ_VEC, irq_ack=1 for one cycle; this overrides the jump redirect.
  - Next state is FETCH regardless of run.
- irq is sampled only at instruction boundaries. ret_pc resets to 0.
- Disabled: ports are absent and behaviour is exactly as above.

Test Plan:
- Reset release: pc_ld pulses once with pc_ld_val=16'h0000. Then, with run=0, the block stays IDLE and mem_req remains 0.
- run=1, zero-wait memory returns 8'h05: ir=8'h05, operand=0, a single pc_inc pulse, instr_valid 2 cycles after FETCH entry. exec_done -> retired_cnt=1.
- 3-byte fetch of 8'h80, 8'h34, 8'h12 with mem_ack delayed 2 cycles each: operand=16'h1234, exactly 3 pc_inc pulses, mem_req held through each wait.
- exec_done with jump_req=1 and jump_addr=16'h0100: pc_ld pulses with value 16'h0100 and no pc_inc in that cycle. Same stimulus with halt=1: halted=1, no pc_ld, no further mem_req.
- rst_n low while mem_req=1 in OPR_HI: mem_req drops immediately. After release, BOOT reloads RESET_VEC. retired_cnt preset near 16'hFFFF wraps to 0.
- FETCH_IRQ_EN: irq=1 at exec_done with jump to 16'h0200 -> pc_ld_val=16'h00F0, irq_ack pulses, ret_pc=16'h0200.
